sprite_motion_ctrl: RTL and testbench

Frame-synchronous motion and animation sequencer for the walking-sprite VGA demo. It watches the raster position from the `hvsync_generator` and detects the start of vertical blanking. Once per frame, during blanking only, it steps the sprite position, bounces it between programmable bounds and advances the walk-cycle frame index. The sprite ROM and pixel mux consume its registered outputs, which never change during active video.

---
 rtl/vga_pkg.sv | 16 +
 rtl/bounce_axis.sv | 49 ++++
 rtl/sprite_motion_ctrl.sv | 141 ++++++++++++++
 tb/tb_sprite_motion_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the sprite motion FSM state type.
package vga_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned SPRITE_W = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWaitVbl,
        StUpdX,
        StUpdY,
        StUpdAnim
    } motion_state_t;

endpackage

// File: rtl/bounce_axis.sv
// Combinational next position / next direction for one bouncing axis.
module bounce_axis #(
    parameter int unsigned MIN  = 100,
    parameter int unsigned MAX  = 400,
    parameter int unsigned STEP = 1
) (
    input  logic [9:0] pos,
    input  logic       dir,
    output logic [9:0] pos_next,
    output logic       dir_next
);

    localparam logic [10:0] MIN_W  = 11'(MIN);
    localparam logic [10:0] MAX_W  = 11'(MAX);
    localparam logic [10:0] STEP_W = 11'(STEP);

    logic [10:0] pos_w;
    logic [10:0] sum_w;
    logic [10:0] diff_w;
    logic [10:0] lo_lim_w;

    // 11-bit arithmetic so the right-hand sum cannot wrap past 1023
    assign pos_w    = {1'b0, pos};
    assign sum_w    = pos_w + STEP_W;
    assign diff_w   = pos_w - STEP_W;
    assign lo_lim_w = MIN_W + STEP_W;

    // Clamp at the bound and reverse; the left test avoids the subtraction underflowing
    always_comb begin
        pos_next = pos;
        dir_next = dir;
        if (dir) begin
            if (sum_w >= MAX_W) begin
                pos_next = MAX_W[9:0];
                dir_next = 1'b0;
            end else begin
                pos_next = sum_w[9:0];
            end
        end else begin
            if (pos_w < lo_lim_w) begin
                pos_next = MIN_W[9:0];
                dir_next = 1'b1;
            end else begin
                pos_next = diff_w[9:0];
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite motion and walk-cycle sequencer. All updates happen
// in the few clocks after vblank start, so outputs are stable in active video.
module sprite_motion_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned X_MIN           = 100,
    parameter int unsigned X_MAX           = 400,
    parameter int unsigned Y_MIN           = 100,
    parameter int unsigned Y_MAX           = 300,
    parameter int unsigned X_STEP          = 1,
    parameter int unsigned Y_STEP          = 0,
    parameter int unsigned FRAMES_PER_ANIM = 8,
    parameter int unsigned V_ACTIVE        = vga_pkg::V_ACTIVE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hpos,
    input  logic [9:0] vpos,
    input  logic       enable,
    input  logic       pause,
    input  logic       step,
    output logic [9:0] sprite_x,
    output logic [9:0] sprite_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic [1:0] anim_frame,
    output logic       frame_tick,
    output logic       busy
);

    localparam int unsigned CNT_W = (FRAMES_PER_ANIM > 1) ? $clog2(FRAMES_PER_ANIM) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_ANIM - 1);

    motion_state_t    state_q;
    logic             step_pend_q;
    logic [CNT_W-1:0] anim_cnt_q;
    logic             vbl;
    logic             enter_x;
    logic [9:0]       x_next;
    logic [9:0]       y_next;
    logic             dx_next;
    logic             dy_next;

    assign vbl     = (hpos == 10'd0) && (vpos == 10'(V_ACTIVE));
    assign enter_x = (state_q == StWaitVbl) && enable && vbl && (!pause || step_pend_q);

    bounce_axis #(
        .MIN  (X_MIN),
        .MAX  (X_MAX),
        .STEP (X_STEP)
    ) u_axis_x (
        .pos      (sprite_x),
        .dir      (dir_x),
        .pos_next (x_next),
        .dir_next (dx_next)
    );

    bounce_axis #(
        .MIN  (Y_MIN),
        .MAX  (Y_MAX),
        .STEP (Y_STEP)
    ) u_axis_y (
        .pos      (sprite_y),
        .dir      (dir_y),
        .pos_next (y_next),
        .dir_next (dy_next)
    );

    // Step latch: only a step while paused is remembered; consumed when an update starts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_pend_q <= 1'b0;
        end else begin
            step_pend_q <= (step_pend_q && !enter_x) || (step && pause);
        end
    end

    // Frame strobe: registered vblank start, suppressed only while parked in idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= vbl && (state_q != StIdle);
        end
    end

    // Update sequencer: one axis / animation stage per clock after vblank
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            sprite_x   <= 10'(X_MIN);
            sprite_y   <= 10'(Y_MIN);
            dir_x      <= 1'b1;
            dir_y      <= 1'b1;
            anim_frame <= 2'd0;
            anim_cnt_q <= '0;
            busy       <= 1'b0;
        end else if (!enable) begin
            // Park immediately; values already written are kept as they are
            state_q <= StIdle;
            busy    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StWaitVbl;
                end
                StWaitVbl: begin
                    if (enter_x) begin
                        state_q <= StUpdX;
                        busy    <= 1'b1;
                    end
                end
                StUpdX: begin
                    sprite_x <= x_next;
                    dir_x    <= dx_next;
                    state_q  <= StUpdY;
                end
                StUpdY: begin
                    sprite_y <= y_next;
                    dir_y    <= dy_next;
                    state_q  <= StUpdAnim;
                end
                StUpdAnim: begin
                    if (anim_cnt_q == CNT_LAST) begin
                        anim_cnt_q <= '0;
                        anim_frame <= anim_frame + 2'd1;
                    end else begin
                        anim_cnt_q <= anim_cnt_q + CNT_W'(1);
                    end
                    state_q <= StWaitVbl;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: two instances (default parameters and a small,
// fast-bouncing configuration) driven with shortened synthetic frames.
module tb_sprite_motion_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       enable;
    logic       pause;
    logic       step;

    logic [9:0] x0, y0, x1, y1;
    logic       dx0, dy0, dx1, dy1;
    logic [1:0] anim0, anim1;
    logic       ft0, ft1, busy0, busy1;

    always #5 clk = ~clk;

    sprite_motion_ctrl u_dut0 (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .enable     (enable),
        .pause      (pause),
        .step       (step),
        .sprite_x   (x0),
        .sprite_y   (y0),
        .dir_x      (dx0),
        .dir_y      (dy0),
        .anim_frame (anim0),
        .frame_tick (ft0),
        .busy       (busy0)
    );

    sprite_motion_ctrl #(
        .X_MIN           (100),
        .X_MAX           (111),
        .Y_MIN           (50),
        .Y_MAX           (60),
        .X_STEP          (3),
        .Y_STEP          (4),
        .FRAMES_PER_ANIM (1)
    ) u_dut1 (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .enable     (enable),
        .pause      (pause),
        .step       (step),
        .sprite_x   (x1),
        .sprite_y   (y1),
        .dir_x      (dx1),
        .dir_y      (dy1),
        .anim_frame (anim1),
        .frame_tick (ft1),
        .busy       (busy1)
    );

    // Per-instance configuration for the reference model
    int p_xmin[2] = '{100, 100};
    int p_xmax[2] = '{400, 111};
    int p_xst[2]  = '{1, 3};
    int p_ymin[2] = '{100, 50};
    int p_ymax[2] = '{300, 60};
    int p_yst[2]  = '{0, 4};
    int p_fpa[2]  = '{8, 1};

    // Reference state: positions, directions, number of completed updates
    int m_x[2], m_y[2], m_dx[2], m_dy[2], m_upd[2];
    bit m_pend;

    int n_checks = 0;
    int n_err    = 0;
    int tk0 = 0;
    int tk1 = 0;

    always @(negedge clk) begin
        if (ft0) tk0++;
        if (ft1) tk1++;
    end

    typedef struct {
        bit pause;
        bit step;
        int n;
        int exp_x;
        int exp_dx;
        int exp_anim;
        int exp_ticks;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void axis(input int pos, input int dir, input int mn, input int mx,
                                 input int st, output int npos, output int ndir);
        npos = pos;
        ndir = dir;
        if (dir == 1) begin
            if (pos + st >= mx) begin
                npos = mx;
                ndir = 0;
            end else begin
                npos = pos + st;
            end
        end else begin
            if (pos - st < mn) begin
                npos = mn;
                ndir = 1;
            end else begin
                npos = pos - st;
            end
        end
    endfunction

    function automatic int m_anim(input int i);
        return (m_upd[i] / p_fpa[i]) % 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_x[i]   = p_xmin[i];
            m_y[i]   = p_ymin[i];
            m_dx[i]  = 1;
            m_dy[i]  = 1;
            m_upd[i] = 0;
        end
        m_pend = 0;
    endtask

    task automatic model_frame(input bit en, input bit p, input bit s);
        int nx, nd;
        if (s && p) m_pend = 1;
        if (en && (!p || m_pend)) begin
            for (int i = 0; i < 2; i++) begin
                axis(m_x[i], m_dx[i], p_xmin[i], p_xmax[i], p_xst[i], nx, nd);
                m_x[i]  = nx;
                m_dx[i] = nd;
                axis(m_y[i], m_dy[i], p_ymin[i], p_ymax[i], p_yst[i], nx, nd);
                m_y[i]  = nx;
                m_dy[i] = nd;
                m_upd[i]++;
            end
            m_pend = 0;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, " x0"}, int'(x0), m_x[0]);
        chk({tag, " dx0"}, int'(dx0), m_dx[0]);
        chk({tag, " y0"}, int'(y0), m_y[0]);
        chk({tag, " anim0"}, int'(anim0), m_anim(0));
        chk({tag, " x1"}, int'(x1), m_x[1]);
        chk({tag, " dx1"}, int'(dx1), m_dx[1]);
        chk({tag, " y1"}, int'(y1), m_y[1]);
        chk({tag, " dy1"}, int'(dy1), m_dy[1]);
        chk({tag, " anim1"}, int'(anim1), m_anim(1));
    endtask

    // One shortened frame: two lead-in cycles (step pulse in the first), the
    // vblank cycle, then six cycles for the update sequence to drain.
    task automatic run_frame(input bit en, input bit p, input bit s);
        enable = en;
        pause  = p;
        step   = s;
        tick();
        step = 1'b0;
        tick();
        hpos = 10'd0;
        vpos = 10'd480;
        tick();
        hpos = 10'd5;
        vpos = 10'd0;
        repeat (6) tick();
        model_frame(en, p, s);
    endtask

    vec_t vecs[9];

    initial begin
        int t0, t1, ex0, ex1, nd;
        bit en, p, s;

        // pause, step, frames, x0, dir_x0, anim0, frame_tick pulses
        vecs[0] = '{0, 0, 7,   108, 1, 1, 7};
        vecs[1] = '{1, 0, 5,   108, 1, 1, 5};
        vecs[2] = '{1, 1, 1,   109, 1, 1, 1};
        vecs[3] = '{1, 0, 2,   109, 1, 1, 2};
        vecs[4] = '{0, 1, 1,   110, 1, 1, 1};
        vecs[5] = '{1, 0, 1,   110, 1, 1, 1};
        vecs[6] = '{0, 0, 23,  133, 1, 0, 23};
        vecs[7] = '{0, 0, 267, 400, 0, 1, 267};
        vecs[8] = '{0, 0, 1,   399, 0, 1, 1};

        reset  = 1'b1;
        enable = 1'b0;
        pause  = 1'b0;
        step   = 1'b0;
        hpos   = 10'd5;
        vpos   = 10'd0;
        repeat (3) tick();

        chk("reset x0", int'(x0), 100);
        chk("reset y0", int'(y0), 100);
        chk("reset dx0", int'(dx0), 1);
        chk("reset dy0", int'(dy0), 1);
        chk("reset anim0", int'(anim0), 0);
        chk("reset tick0", int'(ft0), 0);
        chk("reset busy0", int'(busy0), 0);
        chk("reset x1", int'(x1), 100);
        chk("reset y1", int'(y1), 50);

        @(negedge clk);
        reset = 1'b0;
        model_reset();
        tick();
        enable = 1'b1;
        tick();

        // First update, stage by stage
        hpos = 10'd0;
        vpos = 10'd480;
        tick();
        hpos = 10'd5;
        vpos = 10'd0;
        chk("T+1 frame_tick", int'(ft0), 1);
        chk("T+1 busy", int'(busy0), 1);
        chk("T+1 x0 unchanged", int'(x0), 100);
        tick();
        chk("T+2 x0", int'(x0), 101);
        chk("T+2 dx0", int'(dx0), 1);
        chk("T+2 frame_tick low", int'(ft0), 0);
        chk("T+2 busy", int'(busy0), 1);
        chk("T+2 x1", int'(x1), 103);
        chk("T+2 y1 unchanged", int'(y1), 50);
        tick();
        chk("T+3 y1", int'(y1), 54);
        chk("T+3 busy", int'(busy0), 1);
        chk("T+3 anim1 unchanged", int'(anim1), 0);
        tick();
        chk("T+4 anim1", int'(anim1), 1);
        chk("T+4 anim0", int'(anim0), 0);
        chk("T+4 busy", int'(busy0), 0);
        repeat (3) tick();
        chk("first frame tick count", tk0, 1);
        model_frame(1'b1, 1'b0, 1'b0);
        check_model("first frame");

        // Directed frame sequences
        foreach (vecs[k]) begin
            t0 = tk0;
            for (int f = 0; f < vecs[k].n; f++) begin
                run_frame(1'b1, vecs[k].pause, (f == 0) ? vecs[k].step : 1'b0);
            end
            chk($sformatf("vec%0d x0", k), int'(x0), vecs[k].exp_x);
            chk($sformatf("vec%0d dx0", k), int'(dx0), vecs[k].exp_dx);
            chk($sformatf("vec%0d anim0", k), int'(anim0), vecs[k].exp_anim);
            chk($sformatf("vec%0d ticks", k), tk0 - t0, vecs[k].exp_ticks);
            check_model($sformatf("vec%0d", k));
        end
        pause = 1'b0;

        // Enable dropped during the y stage: x already written, animation skipped
        hpos = 10'd0;
        vpos = 10'd480;
        tick();
        hpos = 10'd5;
        vpos = 10'd0;
        tick();
        enable = 1'b0;
        tick();
        chk("abort busy", int'(busy0), 0);
        repeat (3) tick();
        axis(m_x[0], m_dx[0], p_xmin[0], p_xmax[0], p_xst[0], ex0, nd);
        axis(m_x[1], m_dx[1], p_xmin[1], p_xmax[1], p_xst[1], ex1, nd);
        chk("abort x0", int'(x0), ex0);
        chk("abort x1", int'(x1), ex1);
        chk("abort anim1 held", int'(anim1), m_anim(1));

        // Vblank while disabled: no strobe, no update
        t0 = tk0;
        hpos = 10'd0;
        vpos = 10'd480;
        tick();
        hpos = 10'd5;
        vpos = 10'd0;
        repeat (4) tick();
        chk("idle no tick", tk0 - t0, 0);
        chk("idle x0 held", int'(x0), ex0);

        // Asynchronous reset in the middle of an update sequence
        enable = 1'b1;
        repeat (2) tick();
        hpos = 10'd0;
        vpos = 10'd480;
        tick();
        hpos = 10'd5;
        vpos = 10'd0;
        tick();
        chk("pre-reset x0 moved", int'(x0), ex0 - 1);
        #2 reset = 1'b1;
        #1;
        chk("async reset x0", int'(x0), 100);
        chk("async reset dx0", int'(dx0), 1);
        chk("async reset anim0", int'(anim0), 0);
        chk("async reset busy0", int'(busy0), 0);
        chk("async reset x1", int'(x1), 100);
        chk("async reset y1", int'(y1), 50);
        chk("async reset anim1", int'(anim1), 0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        repeat (4) tick();
        chk("post-reset x0", int'(x0), 100);
        chk("post-reset busy0", int'(busy0), 0);
        chk("post-reset tick0", int'(ft0), 0);

        // Randomised frames against the reference model
        for (int r = 0; r < 60; r++) begin
            en = ($urandom % 8) != 0;
            p  = ($urandom % 3) == 0;
            s  = en && (($urandom % 2) == 1);
            t0 = tk0;
            t1 = tk1;
            run_frame(en, p, s);
            chk($sformatf("rand%0d ticks0", r), tk0 - t0, en ? 1 : 0);
            chk($sformatf("rand%0d ticks1", r), tk1 - t1, en ? 1 : 0);
            chk($sformatf("rand%0d busy", r), int'(busy0), 0);
            check_model($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
